m_unit_seq: RTL and testbench
=============================

# m_unit_seq

Sequencer and operand/state register file for the RV32M multiply/divide unit. Accepts one M-extension operation at a time, drives the combinational M-unit ALU datapath (`m_alu`) with the multiplier operands and with the R/D/Z division registers, and consumes the datapath's subtract, product and select results. Division uses a 32-step restoring algorithm; multiplication completes in one datapath cycle. It sits between the execute-stage issue logic and `m_alu`, and returns a 32-bit result with a one-cycle valid pulse.

## Interface
- No parameters; widths are fixed for RV32 (XLEN 32, 32 division steps).
- `clk` in 1: rising-edge clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `start` in 1: request; sampled only in IDLE.
- `funct3` in 3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `rs1`, `rs2` in 32: operands, sampled with `start`.
- `busy` out 1: state != IDLE.
- `result_valid` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: held from `result_valid` until the next accepted `start`.
- `R` out 32, `D` out 63, `Z` out 32: remainder, divisor and quotient registers to the datapath.
- `mult_a`, `mult_b` out 33 signed: registered multiplier operands.
- `mux_div_rem` out `MUX_DIV_REM_LENGTH`: `MUX_DIV_REM_Z` for DIV/DIVU, `MUX_DIV_REM_R` for REM/REMU.
- `sub_neg` in 1, `sub_result` in 32: sign and low word of R − D.
- `div_rem`, `div_rem_neg` in 32: selected division result and its two's-complement negation.
- `product` in 66 signed: `mult_a * mult_b`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, `start`=1, mul op: load `mult_a`/`mult_b` = `rs1`/`rs2` extended to 33 bits.
  - MUL and MULH: both sign-extended.
  - MULHSU: `rs1` sign-extended, `rs2` zero-extended.
  - MULHU: both zero-extended.
  - Go to MUL.
- MUL: `result` ← `product[31:0]` for MUL, otherwise `product[63:32]`; go to DONE.
- IDLE, `start`=1, div op with `rs2`≠0:
  - `sgn` = funct3 is DIV or REM.
  - R ← |rs1|, D ← {|rs2|, 31'b0}, Z ← 0, where |x| is the two's-complement magnitude when `sgn`, otherwise x.
  - `neg_q` ← `sgn` & (rs1[31] ^ rs2[31]); `neg_r` ← `sgn` & rs1[31].
  - Step counter ← 31; go to DIV.
- DIV, each cycle:
  - If !`sub_neg`: R ← `sub_result`, Z ← {Z[30:0], 1}.
  - Else: Z ← {Z[30:0], 0}, R unchanged.
  - D ← D >> 1.
  - Counter decrements; at counter 0 go to FIX.
- FIX: `result` ← `div_rem_neg` if (`neg_q` for DIV/DIVU, `neg_r` for REM/REMU), else `div_rem`; go to DONE.
- Division by zero is detected in IDLE and does not iterate.
  - `result` ← 0xFFFFFFFF for DIV/DIVU, `rs1` for REM/REMU.
  - Go directly to DONE.
- Signed overflow (0x80000000 / −1) needs no special case: the magnitudes give Z=0x80000000 and R=0, and `neg_q`=0.
- DONE: `result_valid`=1; go to IDLE.
- `start` outside IDLE, including in DONE, is ignored.

## Timing
- `start` accepted in cycle N.
- Multiply: `result_valid` in cycle N+2.
- Divide or remainder: 32 DIV cycles (N+1..N+32), FIX in N+33, `result_valid` in N+34.
- Divide by zero: `result_valid` in cycle N+1.
- `busy` is high from N+1 through the `result_valid` cycle inclusive.
- Reset values: state IDLE; `busy`, `result_valid`, `result`, `R`, `D`, `Z`, `mult_a`, `mult_b` all 0; `mux_div_rem` = `MUX_DIV_REM_Z`.
- `resetn` low at any time, including mid-division, forces all outputs to reset values immediately. No partial result is ever flagged valid.
- `mux_div_rem` is a function of the registered funct3 only; it is stable throughout DIV and FIX.

## Structure
- Shared package `m_definitions`: funct3 encodings, `MUX_DIV_REM_*` constants and length, state enum type.
- No sub-module; the sequencer is pure control plus registers.
- Parent `m_unit` instantiates this block and `m_alu` and wires the datapath ports.

## Test plan
- MUL 7 × −3 → 0xFFFFFFEB at N+2.
- MULH 7 × −3 → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD at N+34.
- REM −7 / 2 → 0xFFFFFFFF at N+34.
- DIVU 100 / 7 → 14.
- REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF at N+1.
- REM −5 / 0 → 0xFFFFFFFB at N+1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- REM 0x80000000 / 0xFFFFFFFF → 0.
- `start` pulsed during DIV and in the DONE cycle → ignored: single valid pulse, first result unchanged.
- `resetn` low at DIV step 10 → all outputs 0 asynchronously.
- After that reset, DIVU 9 / 3 → 3 at N+34.

Source files
------------

// File: rtl/m_definitions.sv
// Shared encodings for the RV32M unit: funct3 codes, division result select and
// the sequencer state type.
package m_definitions;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MUX_DIV_REM_LENGTH = 1;
    localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_Z = 1'b0;
    localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_R = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/m_unit_seq.sv
// RV32M sequencer: single-cycle multiply via external datapath, 32-step
// restoring division over the R/D/Z registers, one-cycle result_valid pulse.
module m_unit_seq
    import m_definitions::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [2:0]                    funct3,
    input  logic [31:0]                   rs1,
    input  logic [31:0]                   rs2,
    output logic                          busy,
    output logic                          result_valid,
    output logic [31:0]                   result,
    output logic [31:0]                   R,
    output logic [62:0]                   D,
    output logic [31:0]                   Z,
    output logic signed [32:0]            mult_a,
    output logic signed [32:0]            mult_b,
    output logic [MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    input  logic                          sub_neg,
    input  logic [31:0]                   sub_result,
    input  logic [31:0]                   div_rem,
    input  logic [31:0]                   div_rem_neg,
    input  logic signed [65:0]            product
);

    state_t      state;
    logic [2:0]  op;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        neg_r;

    logic        sgn;
    logic        sign_a;
    logic        sign_b;
    logic        product_unused;

    assign sgn    = (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign sign_a = (funct3 != F3_MULHU);
    assign sign_b = (funct3 == F3_MUL) || (funct3 == F3_MULH);

    // The top two product bits are pure sign extension for 33x33 operands.
    assign product_unused = ^product[65:64];

    // Driven only from the latched op, so it cannot glitch while DIV/FIX run.
    assign mux_div_rem = op[1] ? MUX_DIV_REM_R : MUX_DIV_REM_Z;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            op           <= F3_MUL;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            R            <= '0;
            D            <= '0;
            Z            <= '0;
            mult_a       <= '0;
            mult_b       <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op   <= funct3;
                        busy <= 1'b1;
                        if (!funct3[2]) begin
                            mult_a <= {sign_a & rs1[31], rs1};
                            mult_b <= {sign_b & rs2[31], rs2};
                            state  <= ST_MUL;
                        end else if (rs2 == 32'd0) begin
                            result       <= funct3[1] ? rs1 : 32'hFFFF_FFFF;
                            result_valid <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            R     <= mag(rs1, sgn);
                            D     <= {mag(rs2, sgn), 31'd0};
                            Z     <= '0;
                            neg_q <= sgn & (rs1[31] ^ rs2[31]);
                            neg_r <= sgn & rs1[31];
                            cnt   <= 5'd31;
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    result       <= (op == F3_MUL) ? product[31:0] : product[63:32];
                    result_valid <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DIV: begin
                    if (!sub_neg)
                        R <= sub_result;
                    Z   <= {Z[30:0], ~sub_neg};
                    D   <= D >> 1;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result       <= (op[1] ? neg_r : neg_q) ? div_rem_neg : div_rem;
                    result_valid <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_unit_seq.sv
// Directed bench for m_unit_seq with a behavioural model of the m_alu datapath.
module tb_m_unit_seq;
    import m_definitions::*;

    logic                          clk = 1'b0;
    logic                          resetn = 1'b0;
    logic                          start = 1'b0;
    logic [2:0]                    funct3 = 3'd0;
    logic [31:0]                   rs1 = 32'd0;
    logic [31:0]                   rs2 = 32'd0;
    logic                          busy;
    logic                          result_valid;
    logic [31:0]                   result;
    logic [31:0]                   R;
    logic [62:0]                   D;
    logic [31:0]                   Z;
    logic signed [32:0]            mult_a;
    logic signed [32:0]            mult_b;
    logic [MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
    logic                          sub_neg;
    logic [31:0]                   sub_result;
    logic [31:0]                   div_rem;
    logic [31:0]                   div_rem_neg;
    logic signed [65:0]            product;

    int n_cmp = 0;
    int n_err = 0;

    m_unit_seq dut (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy), .result_valid(result_valid),
        .result(result), .R(R), .D(D), .Z(Z), .mult_a(mult_a), .mult_b(mult_b),
        .mux_div_rem(mux_div_rem), .sub_neg(sub_neg), .sub_result(sub_result),
        .div_rem(div_rem), .div_rem_neg(div_rem_neg), .product(product)
    );

    always #5 clk = ~clk;

    // m_alu model: R - D over 64 bits, result select, negation, 66-bit product.
    logic [63:0] diff;
    assign diff        = {32'd0, R} - {1'b0, D};
    assign sub_neg     = diff[63];
    assign sub_result  = diff[31:0];
    assign div_rem     = (mux_div_rem == MUX_DIV_REM_R) ? R : Z;
    assign div_rem_neg = ~div_rem + 32'd1;
    assign product     = 66'(mult_a) * 66'(mult_b);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        while (!result_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, 64'(result), 64'(exp_res));
        @(posedge clk); #1;
        chk({tag, " pulse"}, 64'(result_valid), 64'd0);
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        #12;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(result_valid), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst D", 64'(D), 64'd0);
        chk("rst mux", 64'(mux_div_rem), 64'(MUX_DIV_REM_Z));
        resetn = 1'b1;

        run("mul",    F3_MUL,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        run("mulh",   F3_MULH,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 2);
        run("mulhu",  F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run("div",    F3_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
        run("rem",    F3_REM,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
        run("divu",   F3_DIVU,  32'd100,      32'd7,         32'd14,        34);
        run("remu",   F3_REMU,  32'd100,      32'd7,         32'd2,         34);
        run("div0",   F3_DIV,   32'd5,        32'd0,         32'hFFFF_FFFF, 1);
        run("rem0",   F3_REM,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1);
        run("divovf", F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run("removf", F3_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        34);

        // start pulses during DIV and in the DONE cycle must be ignored
        @(posedge clk); #1;
        funct3 = F3_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!result_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("ign latency", 64'(lat), 64'd34);
        chk("ign result", 64'(result), 64'd14);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign done valid", 64'(result_valid), 64'd0);
        chk("ign done busy", 64'(busy), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("ign no 2nd valid", 64'(result_valid), 64'd0);
        chk("ign held", 64'(result), 64'd14);

        // asynchronous reset in the middle of a division
        @(posedge clk); #1;
        funct3 = F3_REM; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("pre-rst busy", 64'(busy), 64'd1);
        chk("pre-rst mux", 64'(mux_div_rem), 64'(MUX_DIV_REM_R));
        #2 resetn = 1'b0;
        #1;
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst result", 64'(result), 64'd0);
        chk("arst R", 64'(R), 64'd0);
        chk("arst D", 64'(D), 64'd0);
        chk("arst Z", 64'(Z), 64'd0);
        chk("arst mult_a", 64'(mult_a), 64'd0);
        chk("arst mult_b", 64'(mult_b), 64'd0);
        chk("arst mux", 64'(mux_div_rem), 64'(MUX_DIV_REM_Z));
        @(posedge clk); #1;
        chk("arst valid", 64'(result_valid), 64'd0);
        #2 resetn = 1'b1;

        run("post divu", F3_DIVU, 32'd9, 32'd3, 32'd3, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
